// File: rtl/decoder_pulse_seq_pkg.sv
// Shared definitions for the pulse-sequenced decoder: FSM state encodings,
// default timing parameters and a small elaboration-time helper.
package decoder_pulse_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   localparam int DEF_PULSE_LEN = 4;
   localparam int DEF_GAP_LEN   = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/decoder_pulse_seq_onehot_dec.sv
// Combinational binary-to-one-hot decoder: code value k raises line k only.
module onehot_dec #(
   parameter  int CODE_W = 2,
   localparam int OUT_W  = 2**CODE_W
) (
   input  logic [CODE_W-1:0] code,
   output logic [OUT_W-1:0]  y
);

   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_line
         assign y[gi] = (code == CODE_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/decoder_pulse_seq.sv
// Sequenced one-hot decoder: each accepted code drives y for PULSE_LEN cycles,
// then GAP_LEN dead cycles. Optional abort input via DECODER_PULSE_ABORT_EN.
module decoder_pulse_seq
   import decoder_pulse_seq_pkg::*;
#(
   parameter  int CODE_W    = 2,
   parameter  int PULSE_LEN = DEF_PULSE_LEN,
   parameter  int GAP_LEN   = DEF_GAP_LEN,
   localparam int OUT_W     = 2**CODE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] code,
`ifdef DECODER_PULSE_ABORT_EN
   input  logic              abort,
`endif
   output logic [OUT_W-1:0]  y,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(max_int(PULSE_LEN, GAP_LEN) + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [OUT_W-1:0] y_reg, y_next, dec;
   logic             done_reg, done_next, busy_reg;
   logic             xfer, abort_req;

   onehot_dec #(.CODE_W(CODE_W)) u_dec (
      .code (code),
      .y    (dec)
   );

   assign in_ready = (state_reg == ST_IDLE) & ~rst;
   assign xfer     = in_valid & in_ready;

`ifdef DECODER_PULSE_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      y_next     = y_reg;
      done_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (xfer) begin
               state_next = ST_ACTIVE;
               y_next     = dec;
               cnt_next   = PULSE_LOAD;
            end
         end
         ST_ACTIVE: begin
            // abort wins over the counter, so a final-cycle abort also suppresses done
            if (abort_req) begin
               state_next = ST_IDLE;
               y_next     = '0;
               cnt_next   = '0;
            end else if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CNT_W'(1);
            end else begin
               y_next    = '0;
               done_next = 1'b1;
               if (GAP_LEN > 0) begin
                  state_next = ST_GAP;
                  cnt_next   = GAP_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            y_next = '0;
            if (abort_req || cnt_reg == '0) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            y_next     = '0;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         y_reg     <= '0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         y_reg     <= y_next;
         done_reg  <= done_next;
         busy_reg  <= (state_next != ST_IDLE);
      end
   end

   assign y    = y_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_decoder_pulse_seq.sv
// Self-checking bench: default instance plus a PULSE_LEN=1/GAP_LEN=0 instance,
// both compared each cycle against a timeline model of every accepted code.
module tb_decoder_pulse_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iv   [2];
   logic [1:0] cd   [2];
   logic       rdy  [2];
   logic [3:0] yo   [2];
   logic       bsy  [2];
   logic       dn   [2];
   logic       ab0 = 1'b0;

   int errors = 0;
   int checks = 0;

   // model: per instance, the cycle window of the current pulse and its done/ready edges
   int pl [2] = '{4, 1};
   int gl [2] = '{1, 0};
   int edge_n;
   int y_start [2], y_end [2], done_edge [2], ready_edge [2];
   logic [3:0] oh [2];
   logic last_xf [2];

   always #5 clk = ~clk;

   decoder_pulse_seq dut0 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[0]),
      .in_ready (rdy[0]),
      .code     (cd[0]),
`ifdef DECODER_PULSE_ABORT_EN
      .abort    (ab0),
`endif
      .y        (yo[0]),
      .busy     (bsy[0]),
      .done     (dn[0])
   );

   decoder_pulse_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[1]),
      .in_ready (rdy[1]),
      .code     (cd[1]),
`ifdef DECODER_PULSE_ABORT_EN
      .abort    (1'b0),
`endif
      .y        (yo[1]),
      .busy     (bsy[1]),
      .done     (dn[1])
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         y_start[i]    = -1000;
         y_end[i]      = -1000;
         done_edge[i]  = -1000;
         ready_edge[i] = edge_n;
         oh[i]         = 4'b0;
      end
   endtask

   task automatic check_all(input string ph);
      for (int i = 0; i < 2; i++) begin
         logic       r_e;
         logic [3:0] y_e;
         r_e = (edge_n >= ready_edge[i]);
         y_e = (edge_n >= y_start[i] && edge_n < y_end[i]) ? oh[i] : 4'b0;
         chk($sformatf("%s.i%0d.e%0d.y", ph, i, edge_n), {4'b0, yo[i]}, {4'b0, y_e});
         chk($sformatf("%s.i%0d.e%0d.ready", ph, i, edge_n), {7'b0, rdy[i]}, {7'b0, r_e});
         chk($sformatf("%s.i%0d.e%0d.busy", ph, i, edge_n), {7'b0, bsy[i]}, {7'b0, ~r_e});
         chk($sformatf("%s.i%0d.e%0d.done", ph, i, edge_n), {7'b0, dn[i]},
             {7'b0, (edge_n == done_edge[i])});
      end
   endtask

   // one clock: predict transfers/aborts from the model, apply the edge, check at negedge
   task automatic step(input string ph);
      logic xf [2];
      logic ab [2];
      for (int i = 0; i < 2; i++) begin
         xf[i] = iv[i] && (edge_n >= ready_edge[i]);
         ab[i] = 1'b0;
      end
`ifdef DECODER_PULSE_ABORT_EN
      ab[0] = ab0 && (edge_n < ready_edge[0]);
`endif
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 2; i++) begin
         last_xf[i] = xf[i];
         if (xf[i]) begin
            oh[i]         = 4'b0001 << cd[i];
            y_start[i]    = edge_n;
            y_end[i]      = edge_n + pl[i];
            done_edge[i]  = edge_n + pl[i];
            ready_edge[i] = edge_n + pl[i] + gl[i];
         end else if (ab[i]) begin
            if (y_end[i] > edge_n) y_end[i] = edge_n;
            if (done_edge[i] >= edge_n) done_edge[i] = -1000;
            ready_edge[i] = edge_n;
         end
      end
      @(negedge clk);
      check_all(ph);
   endtask

   initial begin
      int idx [2];
      edge_n = 0;
      iv[0] = 0; iv[1] = 0; cd[0] = 0; cd[1] = 0;

      // held in reset: everything quiet, in_ready forced low
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst.i%0d.ready", i), {7'b0, rdy[i]}, 8'd0);
         chk($sformatf("rst.i%0d.y", i), {4'b0, yo[i]}, 8'd0);
         chk($sformatf("rst.i%0d.busy", i), {7'b0, bsy[i]}, 8'd0);
         chk($sformatf("rst.i%0d.done", i), {7'b0, dn[i]}, 8'd0);
      end
      rst = 1'b0;
      model_reset();
      #1 check_all("release");
      step("idle");

      // single code 2 on both instances
      iv[0] = 1; cd[0] = 2'd2; iv[1] = 1; cd[1] = 2'd2;
      step("single");
      iv[0] = 0; iv[1] = 0;
      repeat (8) step("single");

      // stream 0..3 with in_valid held; code advances only on accepted transfers
      idx[0] = 0; idx[1] = 0;
      iv[0] = 1; iv[1] = 1;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 2; i++) begin
            iv[i] = (idx[i] < 4);
            cd[i] = 2'(idx[i] & 3);
         end
         step("stream");
         for (int i = 0; i < 2; i++) if (last_xf[i]) idx[i]++;
      end
      chk("stream.i0.count", 8'(idx[0]), 8'd4);
      chk("stream.i1.count", 8'(idx[1]), 8'd4);
      iv[0] = 0; iv[1] = 0;

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 2; i++) begin
            iv[i] = ($urandom_range(0, 3) != 0);
            cd[i] = 2'($urandom_range(0, 3));
         end
`ifdef DECODER_PULSE_ABORT_EN
         ab0 = ($urandom_range(0, 9) == 0);
`endif
         step("rand");
      end
      iv[0] = 0; iv[1] = 0; ab0 = 0;
      repeat (7) step("drain");

      // asynchronous reset in the middle of a code-3 pulse
      iv[0] = 1; cd[0] = 2'd3;
      step("midrst");
      iv[0] = 0;
      step("midrst");
      #2 rst = 1'b1;
      #1;
      chk("midrst.y", {4'b0, yo[0]}, 8'd0);
      chk("midrst.done", {7'b0, dn[0]}, 8'd0);
      chk("midrst.busy", {7'b0, bsy[0]}, 8'd0);
      chk("midrst.ready", {7'b0, rdy[0]}, 8'd0);
      repeat (2) @(negedge clk);
      chk("midrst.nodone", {7'b0, dn[0]}, 8'd0);
      rst = 1'b0;
      model_reset();
      #1 check_all("postrst");
      iv[0] = 1; cd[0] = 2'd1;
      step("postrst");
      iv[0] = 0;
      repeat (7) step("postrst");

`ifdef DECODER_PULSE_ABORT_EN
      // abort during the second ACTIVE cycle
      iv[0] = 1; cd[0] = 2'd0;
      step("abort");
      iv[0] = 0;
      step("abort");
      ab0 = 1;
      step("abort");
      ab0 = 0;
      chk("abort.ready", {7'b0, rdy[0]}, 8'd1);
      repeat (4) step("abort");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
